tmip_out_deser: RTL
===================

Name: tmip_out_deser

Overview:
Receive-side deserializer for the TMIP serial result stream. It sits between the TMIP `out_valid`/`out_value` pins and any word-level consumer, such as the on-chip checker or the pattern scoreboard. It collects MSB-first serial bits into fixed-width result words and counts words per frame. Words are buffered in a small FIFO behind a valid/ready handshake, and protocol errors are flagged.

Parameters:
WORD_W, 20, bits per result word (one output pixel).
FIFO_DEPTH, 4, entries in the output word FIFO (power of two, ≥2).
CNT_W, 8, width of the frame word counter; `frame_words==0` means 2^CNT_W words.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
out_valid  input  1  serial bit strobe from TMIP
out_value  input  1  serial data bit, MSB of each word first
frame_words  input  CNT_W  words in the coming frame; sampled on the first bit of a frame
word_valid  output  1  FIFO head holds a word
word_ready  input  1  consumer accepts head word this cycle
word_data  output  WORD_W  FIFO head word
word_last  output  1  head word is the final word of its frame
frame_done  output  1  one-cycle pulse in the cycle the final word of a frame is pushed
busy  output  1  high while a frame is in progress
err_gap  output  1  sticky: out_valid dropped inside a frame
err_ovf  output  1  sticky: a word was pushed while the FIFO was full and not popping

Behaviour:
- Reset (async, any time including mid-word): all outputs 0.
  - FIFO emptied; shift register and counters cleared; state IDLE.
  - err_gap/err_ovf cleared only by reset.
- States: IDLE, SHIFT. `busy = (state==SHIFT)`.
- IDLE: when out_valid=1:
  - latch frame_words into frame_len;
  - shift in out_value; bit_cnt=1, word_cnt=0;
  - go to SHIFT. If WORD_W==1 the push rule below applies in the same cycle.
- SHIFT with out_valid=1: `shreg <= {shreg[WORD_W-2:0], out_value}`; bit_cnt++.
- When bit_cnt reaches WORD_W on a bit cycle:
  - push {last, word} where `last = (word_cnt+1 == frame_len)`, with frame_len==0 treated as 2^CNT_W;
  - reset bit_cnt; word_cnt++.
- If last is set in that push:
  - frame_done=1 that cycle; next state IDLE.
  - out_valid=1 in the very next cycle starts a new frame (back-to-back legal, no gap required).
- SHIFT with out_valid=0:
  - set err_gap; discard the partial word and remaining frame; go to IDLE next cycle.
  - Words already pushed stay in the FIFO; no frame_done is issued.
- Latency: last bit sampled at edge N → word_valid/word_data valid after edge N (registered FIFO, one-cycle push-to-head).
- FIFO behaviour:
  - pop when word_valid && word_ready;
  - word_data/word_last are stable while word_valid=1 and word_ready=0;
  - word_valid drops the cycle after the last entry is popped, if there is no simultaneous push.
- Full FIFO:
  - push with no pop that cycle: the word is dropped and err_ovf set; counters and frame_done behave as if it had been accepted.
  - push and pop in the same cycle: both occur, count unchanged, no overflow.
- Empty FIFO with push and word_ready=1 in the same cycle: the word is not bypassed; it appears next cycle.
- word_ready while word_valid=0: ignored.
- frame_words is ignored except on a frame's first bit.
- out_value is ignored when out_valid=0.

Test Plan:
1. Single word: frame_words=1, word_ready=1; stream 20 bits of 0x80001 MSB first.
   -> frame_done pulses on the 20th-bit cycle.
   -> next cycle word_valid=1, word_data=0x80001, word_last=1; busy=0 after the 20th bit.
2. Backpressure and overflow: frame_words=5, word_ready=0, words 1..5.
   -> after word 4, FIFO holds 1..4 with word_valid=1.
   -> word 5 dropped, err_ovf=1, frame_done still pulses.
   -> raising word_ready pops 1,2,3,4 in order, word_last=0 on all four.
3. Simultaneous push/pop at full: FIFO full with words A–D; word E completes while word_ready=1.
   -> A popped, E accepted, err_ovf stays 0.
   -> drain yields B,C,D,E.
4. Gap error: frame_words=2; out_valid drops after 7 bits.
   -> err_gap=1 next cycle, busy=0, no word pushed, no frame_done.
   -> a following clean 1-word frame is received correctly with err_gap still 1.
5. Back-to-back frames: two frames of frame_words=2 and 3 with out_valid continuously high for 100 cycles.
   -> five words in order; word_last on words 2 and 5.
   -> frame_done pulses at bit cycles 40 and 100.
6. Reset mid-word: assert rst_n=0 after 11 bits with 2 words queued.
   -> all outputs 0 immediately.
   -> after release, a 1-word frame of 0xFFFFF is received as 0xFFFFF with word_last=1.

Source files
------------

// File: rtl/tmip_out_deser.sv
// TMIP serial result stream deserializer.
// Collects MSB-first serial bits into WORD_W-bit words, tags the final word
// of each frame, and buffers {last, word} in a small FIFO with a valid/ready
// output. Gap and overflow conditions raise sticky error flags.
module tmip_out_deser #(
    parameter int WORD_W     = 20,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              out_valid,
    input  logic              out_value,
    input  logic [CNT_W-1:0]  frame_words,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [WORD_W-1:0] word_data,
    output logic              word_last,
    output logic              frame_done,
    output logic              busy,
    output logic              err_gap,
    output logic              err_ovf
);

    localparam int BW = $clog2(WORD_W + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] WORD_W_C  = BW'(WORD_W);
    localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]    frame_len_q, frame_len_d;
    logic                err_gap_q, err_gap_d;

    logic [BW-1:0]       cnt_base_s, cnt_inc_s;
    logic [CNT_W-1:0]    wcnt_base_s, flen_s;
    logic [CNT_W:0]      wnext_s, flen_ext_s;
    logic                push_s, last_s;

    logic [WORD_W:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PW:0]         count_q, count_d;
    logic                err_ovf_q;
    logic                pop_s, full_s, wr_en_s, ovf_s;

    // Next-state for the framing FSM, shift register and bit/word counters.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        frame_len_d = frame_len_q;
        err_gap_d   = err_gap_q;
        cnt_base_s  = {BW{1'b0}};
        wcnt_base_s = {CNT_W{1'b0}};
        flen_s      = frame_len_q;
        push_s      = 1'b0;
        last_s      = 1'b0;

        // In IDLE the first bit of a frame behaves as bit 0 of word 0 with the
        // live frame_words as frame length, so the same push rule covers both.
        case (state_q)
            IDLE: begin
                cnt_base_s  = {BW{1'b0}};
                wcnt_base_s = {CNT_W{1'b0}};
                flen_s      = frame_words;
            end
            SHIFT: begin
                cnt_base_s  = bit_cnt_q;
                wcnt_base_s = word_cnt_q;
                flen_s      = frame_len_q;
            end
            default: begin
                cnt_base_s  = {BW{1'b0}};
                wcnt_base_s = {CNT_W{1'b0}};
                flen_s      = frame_len_q;
            end
        endcase

        cnt_inc_s  = cnt_base_s + BW'(1);
        wnext_s    = {1'b0, wcnt_base_s} + (CNT_W + 1)'(1);
        // A zero frame length stands for 2^CNT_W words.
        flen_ext_s = (flen_s == {CNT_W{1'b0}}) ? {1'b1, {CNT_W{1'b0}}}
                                               : {1'b0, flen_s};

        if (out_valid) begin
            push_s      = (cnt_inc_s == WORD_W_C);
            last_s      = push_s && (wnext_s == flen_ext_s);
            shreg_d     = (shreg_q << 1) | WORD_W'(out_value);
            frame_len_d = flen_s;
            if (push_s) begin
                bit_cnt_d  = {BW{1'b0}};
                word_cnt_d = wnext_s[CNT_W-1:0];
            end else begin
                bit_cnt_d  = cnt_inc_s;
                word_cnt_d = wcnt_base_s;
            end
            if (last_s) begin
                state_d = IDLE;
            end else begin
                state_d = SHIFT;
            end
        end else if (state_q == SHIFT) begin
            // Strobe dropped mid-frame: abandon the partial word and the frame.
            err_gap_d  = 1'b1;
            state_d    = IDLE;
            bit_cnt_d  = {BW{1'b0}};
            word_cnt_d = {CNT_W{1'b0}};
        end else begin
            state_d = state_q;
        end
    end

    // Framing state, shift register, counters and gap flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= {WORD_W{1'b0}};
            bit_cnt_q   <= {BW{1'b0}};
            word_cnt_q  <= {CNT_W{1'b0}};
            frame_len_q <= {CNT_W{1'b0}};
            err_gap_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            frame_len_q <= frame_len_d;
            err_gap_q   <= err_gap_d;
        end
    end

    // FIFO control: a full FIFO still accepts a push when the head pops.
    always_comb begin
        pop_s   = (count_q != {(PW + 1){1'b0}}) && word_ready;
        full_s  = (count_q == DEPTH_C);
        wr_en_s = push_s && (!full_s || pop_s);
        ovf_s   = push_s && full_s && !pop_s;
        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage, pointers, occupancy and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {(WORD_W + 1){1'b0}};
            end
            wr_ptr_q  <= {PW{1'b0}};
            rd_ptr_q  <= {PW{1'b0}};
            count_q   <= {(PW + 1){1'b0}};
            err_ovf_q <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_q[wr_ptr_q] <= {last_s, shreg_d};
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
            if (ovf_s) begin
                err_ovf_q <= 1'b1;
            end
        end
    end

    assign word_valid = (count_q != {(PW + 1){1'b0}});
    assign word_data  = mem_q[rd_ptr_q][WORD_W-1:0];
    assign word_last  = mem_q[rd_ptr_q][WORD_W];
    assign frame_done = last_s;
    assign busy       = (state_q == SHIFT);
    assign err_gap    = err_gap_q;
    assign err_ovf    = err_ovf_q;

endmodule
